bp_update_ctrl: RTL
===================

// Module: bp_update_ctrl
// PURPOSE
//  Sequencer owning the single write port of the local branch predictor tables (BHT + PHT).
//  After reset it sweeps both tables to their initial values over multiple cycles,
//  replacing the one-cycle bulk clear.
//  In run mode it buffers M-stage resolved branches in a small FIFO and issues one table
//  update per accepted handshake.
//  It requests a pipeline stall while initialising or when the FIFO cannot accept a branch.
//  It also keeps a saturating mispredict counter for performance reporting.
// PARAMETERS
//  BHT_DEPTH   10  log2 of BHT entries; BHT index = pc[BHT_DEPTH+1:2]
//  PHT_DEPTH   6   log2 of PHT entries; PHT_DEPTH <= BHT_DEPTH
//  FIFO_DEPTH  4   update FIFO entries; power of two, >= 2
//  CNT_W       32  mispredict counter width
// PORTS
//  clk           in   1          clock, rising edge
//  rst           in   1          reset, asynchronous, active-low (0 = reset)
//  branchM       in   1          M stage holds a resolved branch this cycle
//  pcM           in   32         PC of the M-stage branch
//  actual_takeM  in   1          resolved direction
//  pred_wrong    in   1          M-stage branch was mispredicted (qualified by branchM)
//  upd_ready     in   1          tables accept the command this cycle
//  upd_valid     out  1          command valid
//  upd_init      out  1          1 = init write (BHT<=0, PHT<=2'b11), 0 = normal update
//  upd_idx       out  BHT_DEPTH  init: sweep index; update: pc[BHT_DEPTH+1:2]
//  upd_pc        out  32         update: branch PC (tables derive PHT index); init: 0
//  upd_take      out  1          update: actual direction; init: 0
//  init_busy     out  1          sweep in progress
//  stall_req     out  1          hold F..M pipeline
//  mispred_cnt   out  CNT_W      saturating count of accepted mispredicted branches
// BEHAVIOUR
//  Reset (rst=0, async)
//   - State goes to INIT. Sweep counter, FIFO pointers and mispred_cnt are cleared.
//   - Outputs during reset: upd_valid=0, init_busy=1, stall_req=1.
//  States: INIT -> RUN. There is no other transition; only reset returns the block to INIT.
//  INIT
//   - upd_valid=1, upd_init=1, upd_idx=sweep counter.
//   - The counter advances only on upd_valid&upd_ready.
//   - When the handshake with idx = 2^BHT_DEPTH-1 completes, the next state is RUN.
//   - The tables write the PHT at idx[PHT_DEPTH-1:0] on every init write. This covers
//     the full PHT because PHT_DEPTH <= BHT_DEPTH.
//   - branchM is ignored (no push). stall_req=1, init_busy=1.
//   - Minimum sweep time is 2^BHT_DEPTH cycles (1024 at the default).
//  RUN
//   - Push: branchM & (!full | pop). On push, {pcM[31:0], actual_takeM} is written at
//     the tail.
//   - Pop: upd_valid & upd_ready. upd_valid = !empty; outputs are driven from the head
//     entry with upd_init=0.
//   - Commands are not bypassed: a branch pushed in cycle N is presented no earlier
//     than N+1.
//   - A push and a pop in the same cycle are both performed. When the FIFO is full
//     and a pop occurs, the push is accepted and the count is unchanged.
//   - stall_req = branchM & full & !pop (combinational).
//   - The M stage holds its branch while stalled. The same branch is pushed once, in
//     the cycle stall_req falls.
//   - upd_* must stay stable while upd_valid & !upd_ready.
//   - Pointers wrap modulo FIFO_DEPTH. full/empty are derived from a count of width
//     log2(FIFO_DEPTH)+1.
//  mispred_cnt
//   - Increments by 1 on an accepted push with pred_wrong=1.
//   - Holds at all-ones (saturates).
//   - Does not count in INIT.
//  Updates still queued in the FIFO are not visible to fetch-stage prediction. This
//  stale read is accepted.
//  Reset mid-sweep or mid-queue: all queued entries are discarded and the sweep
//  restarts at index 0.
// STRUCTURE
//  Shared package bp_pkg:
//   - parameters BHT_DEPTH and PHT_DEPTH
//   - counter encodings SNT=2'b00, WNT=2'b01, WT=2'b11, ST=2'b10
//   - PHT_INIT = WT, BHT_INIT = 0
//   - state enum ST_INIT / ST_RUN
//  Sub-module bp_upd_fifo: synchronous FIFO with the width and depth parameterised,
//  exposing push/pop/full/empty.
//  The FSM, sweep counter, output mux and mispredict counter stay in the top level.
// TESTING
//  1. Release rst with upd_ready=1 and BHT_DEPTH=10:
//     - exactly 1024 init commands are issued, idx 0..1023 in order;
//     - init_busy falls in the cycle after idx 1023;
//     - stall_req=1 throughout.
//  2. Toggle upd_ready 1/0 every cycle during INIT:
//     - idx advances only on handshakes and holds when not ready;
//     - the sweep takes 2048 cycles.
//  3. In RUN with upd_ready=0, apply 5 consecutive branches
//     (pcM=0x100,0x104,...; take=1,0,1,0,1):
//     - 4 are accepted;
//     - stall_req=1 on the 5th.
//     Then raise upd_ready:
//     - the 5th is accepted in the same cycle as the first pop;
//     - commands come out in FIFO order with matching pc/take.
//  4. FIFO full, branchM=1 and upd_ready=1 in the same cycle:
//     - stall_req=0;
//     - the count stays 4;
//     - the head advances.
//  5. Send 3 branches with pred_wrong=1 and 2 with pred_wrong=0:
//     - mispred_cnt=3.
//     With CNT_W=4, preload to 15 and send one more mispredict:
//     - mispred_cnt stays 15.
//  6. Assert rst for 1 cycle with 2 entries queued and mid-sweep:
//     - upd_valid=0 immediately (asynchronous);
//     - after release the sweep restarts at idx 0;
//     - the queued entries are never issued.

Source files
------------

// File: rtl/bp_pkg.sv
// bp_pkg: shared constants, counter encodings and types for the local branch predictor update path.
package bp_pkg;
    localparam int BHT_DEPTH = 10;
    localparam int PHT_DEPTH = 6;
    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b11;
    localparam logic [1:0] ST  = 2'b10;
    localparam logic [1:0] PHT_INIT = WT;
    localparam int BHT_INIT = 0;
    typedef enum logic {ST_INIT, ST_RUN} state_e;
    typedef struct packed {
        logic [31:0] pc;
        logic        take;
    } upd_ent_t;
endpackage

// File: rtl/bp_update_ctrl_if.sv
// bp_update_ctrl_if: M-stage branch inputs, table write command bus and status of the update sequencer.
interface bp_update_ctrl_if #(
    parameter int BW = 10,
    parameter int CW = 32
);
    logic          branchM;
    logic [31:0]   pcM;
    logic          actual_takeM;
    logic          pred_wrong;
    logic          upd_ready;
    logic          upd_valid;
    logic          upd_init;
    logic [BW-1:0] upd_idx;
    logic [31:0]   upd_pc;
    logic          upd_take;
    logic          init_busy;
    logic          stall_req;
    logic [CW-1:0] mispred_cnt;
    modport master (
        input  branchM, pcM, actual_takeM, pred_wrong, upd_ready,
        output upd_valid, upd_init, upd_idx, upd_pc, upd_take, init_busy, stall_req, mispred_cnt
    );
    modport slave (
        output branchM, pcM, actual_takeM, pred_wrong, upd_ready,
        input  upd_valid, upd_init, upd_idx, upd_pc, upd_take, init_busy, stall_req, mispred_cnt
    );
endinterface

// File: rtl/bp_upd_fifo.sv
// bp_upd_fifo: synchronous FIFO buffering resolved branches; head entry is presented combinationally.
module bp_upd_fifo #(
    parameter int W     = 33,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] head_q, tail_q;
    logic [AW:0]   cnt_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_i) tail_q <= tail_q + 1'b1;
            if (pop_i) head_q <= head_q + 1'b1;
            cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
        end
    end
    always_ff @(posedge clk) begin
        if (push_i) mem_q[tail_q] <= din_i;
    end
    assign dout_o  = mem_q[head_q];
    assign empty_o = cnt_q == '0;
    assign full_o  = cnt_q == (AW+1)'(DEPTH);
endmodule

// File: rtl/bp_update_ctrl.sv
// bp_update_ctrl: owns the BHT/PHT write port; sweeps the tables after reset,
// then issues one queued branch update per handshake and counts mispredicts.
module bp_update_ctrl #(
    parameter int BHT_DEPTH  = bp_pkg::BHT_DEPTH,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 32
) (
    input logic              clk,
    input logic              rst,
    bp_update_ctrl_if.master bus
);
    import bp_pkg::*;
    localparam int EW = $bits(upd_ent_t);
    state_e               state_q, state_d;
    logic [BHT_DEPTH-1:0] sweep_q, sweep_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 in_init, valid, hs, push, pop, full, empty;
    logic [EW-1:0]        head_raw;
    upd_ent_t             head;
    assign in_init = state_q == ST_INIT;
    assign valid   = in_init | ~empty;
    assign hs      = valid & bus.upd_ready;
    assign pop     = ~in_init & hs;
    assign push    = ~in_init & bus.branchM & (~full | pop);
    assign head    = upd_ent_t'(head_raw);
    bp_upd_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   ({bus.pcM, bus.actual_takeM}),
        .dout_o  (head_raw),
        .full_o  (full),
        .empty_o (empty)
    );
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_INIT;
            sweep_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
            cnt_q   <= cnt_d;
        end
    end
    // The last sweep handshake (all-ones index) hands the write port over to the FIFO.
    always_comb begin
        state_d = (in_init & hs & (&sweep_q)) ? ST_RUN : state_q;
        sweep_d = (in_init & hs) ? sweep_q + 1'b1 : sweep_q;
        cnt_d   = (push & bus.pred_wrong & ~(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
    end
    // Reset gates upd_valid directly so the table port is quiet the moment rst drops.
    always_comb begin
        bus.upd_valid   = rst & valid;
        bus.upd_init    = in_init;
        bus.upd_idx     = in_init ? sweep_q : head.pc[BHT_DEPTH+1:2];
        bus.upd_pc      = in_init ? '0 : head.pc;
        bus.upd_take    = in_init ? 1'b0 : head.take;
        bus.init_busy   = in_init;
        bus.stall_req   = in_init | (bus.branchM & full & ~pop);
        bus.mispred_cnt = cnt_q;
    end
endmodule
